otp_ctrl_otp_arb: RTL and testbench
===================================

# otp_ctrl_otp_arb

Round-robin arbiter that shares the single OTP macro command interface between up to NumReq requesters, such as the partition controllers, the LCI and the DAI. It latches the winning command and drives it to the macro until granted. It then tracks the single outstanding transaction and routes the macro response back to its owner. It sits between the OTP controller requesters and the prim_otp wrapper, and includes escalation lock-down and a response watchdog.

## Interface
- NumReq, default 4: number of requesters, minimum 2.
- TimeoutCycles, default 1024: maximum cycles from issue to response; 0 disables the watchdog.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- escalate_en_i  in  lc_ctrl_pkg::lc_tx_t  escalation; loose-true forces the terminal error state.
- req_i  in  NumReq  per-requester request, held until gnt_o.
- cmd_i  in  NumReq x prim_otp_pkg::cmd_e  per-requester command.
- size_i  in  NumReq x OtpSizeWidth  per-requester size.
- wdata_i  in  NumReq x OtpIfWidth  per-requester write data.
- addr_i  in  NumReq x OtpAddrWidth  per-requester address.
- gnt_o  out  NumReq  one-hot grant pulse.
- rvalid_o  out  NumReq  one-hot response valid.
- rdata_o  out  ScrmblBlockWidth  broadcast read data.
- err_o  out  prim_otp_pkg::err_e  broadcast response error.
- otp_req_o, otp_cmd_o, otp_size_o, otp_wdata_o, otp_addr_o  out  macro command.
- otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i  in  macro handshake and response.
- idle_o  out  1  high in IdleSt with no pending req_i.
- fsm_err_o  out  1  pulse on an invalid state, an unexpected response, or escalation.
- timeout_err_o  out  1  sticky watchdog error.

## Operation
- Sparse-encoded FSM with minimum Hamming distance 5 and four states: IdleSt, ReqSt, WaitSt, ErrorSt. The reset state is IdleSt.
- IdleSt:
  - If any req_i bit is set, pick a winner by round-robin starting at ptr.
  - Latch the winner's index, cmd, size, wdata and addr.
  - Go to ReqSt.
- ReqSt:
  - Drive otp_req_o=1 with the latched payload.
  - When otp_gnt_i=1, pulse gnt_o[owner], set ptr=(owner+1) mod NumReq, and go to WaitSt.
  - Changes on req_i do not affect the latched payload.
- WaitSt:
  - When otp_rvalid_i=1, assert rvalid_o[owner] combinationally, pass otp_rdata_i and otp_err_i through, and go to IdleSt.
- ErrorSt is terminal:
  - otp_req_o=0, all gnt_o and rvalid_o are 0, idle_o=0.
  - Only reset leaves this state.
- Transitions to ErrorSt:
  - Escalation from any state: fsm_err_o pulses every cycle escalation is asserted.
  - Invalid state encoding: fsm_err_o pulses for one cycle.
  - otp_rvalid_i=1 in IdleSt or ReqSt: this is an unexpected response; fsm_err_o pulses.
  - Watchdog expiry: timeout_err_o is set.
- Watchdog:
  - The counter clears on entry to ReqSt and increments every cycle in ReqSt and WaitSt.
  - When cnt==TimeoutCycles-1 and no response has arrived, go to ErrorSt.
  - The counter width is clog2(TimeoutCycles+1) and it saturates.
- Outside ReqSt, otp_wdata_o, otp_addr_o and otp_size_o are driven to '0, and otp_cmd_o is driven to Read.
- Reset values of outputs: otp_req_o=0, all gnt_o/rvalid_o=0, rdata_o='0, err_o=NoError, fsm_err_o=0, timeout_err_o=0. idle_o is 1 when req_i=0.
- Reset of the internal registers: ptr=0, owner=0, latched payload cleared.
- Escalation takes priority over a simultaneous otp_gnt_i or otp_rvalid_i: no gnt_o and no rvalid_o are issued in that cycle.

## Timing
- A req_i asserted in cycle N while in IdleSt produces otp_req_o=1 in cycle N+1.
- gnt_o is asserted in the same cycle as otp_gnt_i.
- rvalid_o is asserted in the same cycle as otp_rvalid_i.
- At most one transaction is outstanding.
- There is a one-cycle IdleSt bubble between transactions. The minimum transaction is 3 cycles (Idle, Req, Wait) when gnt and rvalid each arrive on the first cycle possible.
- Fairness bound: a requester that holds req_i waits at most NumReq-1 other transactions before it is granted.
- Asynchronous reset mid-transaction aborts the transaction immediately. No gnt_o or rvalid_o is generated for the aborted transaction.

## Structure
- The state enum otp_arb_state_e and its sparse encodings go in otp_ctrl_pkg.
- The widths come from the existing otp_ctrl_pkg and prim_otp_pkg constants.
- Sub-module otp_ctrl_rr_pick is a combinational round-robin picker: inputs req vector and ptr; outputs valid and winner index. Its lowest index wins after rotation.
- State registers use PRIM_FLOP_SPARSE_FSM. Payload, owner and ptr use plain async-reset flops.

## Test plan
- Single request: req_i=4'b0100, cmd=Write, addr=0x12, otp_gnt_i after 2 cycles, rvalid after 3 more cycles -> expected response:
  - otp_req_o asserted one cycle after req_i, with addr 0x12.
  - gnt_o=4'b0100 in the otp_gnt_i cycle.
  - rvalid_o=4'b0100 in the rvalid cycle; err_o equals otp_err_i.
- All four requesters held continuously, ptr=0 -> grant order 0,1,2,3,0, with one IdleSt cycle between transactions.
- Payload latch: requester 1 changes wdata from 0xAAAA to 0x5555 while in ReqSt -> otp_wdata_o stays 0xAAAA until otp_gnt_i.
- Escalation in WaitSt together with otp_rvalid_i=1 -> expected response:
  - rvalid_o=0 and fsm_err_o=1 in that cycle.
  - ErrorSt entered; subsequent req_i is ignored, with otp_req_o=0.
- Watchdog with TimeoutCycles=8: otp_gnt_i is never asserted -> ErrorSt is reached 8 cycles after entry to ReqSt, and timeout_err_o stays 1 until reset.
- Unexpected otp_rvalid_i in IdleSt -> fsm_err_o pulses and the FSM enters ErrorSt. Assert rst_ni low afterwards -> FSM returns to IdleSt with ptr=0.

Source files
------------

// File: rtl/otp_ctrl_pkg.sv
// Shared types and widths for the OTP controller arbiter: macro command/error
// encodings, lifecycle escalation encoding and the sparse arbiter FSM states.
package otp_ctrl_pkg;

    parameter int OtpAddrWidth     = 11;
    parameter int OtpSizeWidth     = 2;
    parameter int OtpIfWidth       = 64;
    parameter int ScrmblBlockWidth = 64;

    typedef logic [3:0] lc_tx_t;
    parameter lc_tx_t LcTxOn  = 4'b0101;
    parameter lc_tx_t LcTxOff = 4'b1010;

    // Anything other than the exact Off pattern counts as escalation.
    function automatic logic lc_tx_test_true_loose(input lc_tx_t val);
        return val != LcTxOff;
    endfunction

    typedef enum logic [1:0] {
        Read     = 2'b00,
        Write    = 2'b01,
        ReadRaw  = 2'b10,
        WriteRaw = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        NoError              = 3'h0,
        MacroError           = 3'h1,
        MacroEccCorrError    = 3'h2,
        MacroEccUncorrError  = 3'h3,
        MacroWriteBlankError = 3'h4
    } err_e;

    // Pairwise Hamming distance of these encodings is at least 5.
    typedef enum logic [9:0] {
        IdleSt  = 10'b11111_00000,
        ReqSt   = 10'b00000_11111,
        WaitSt  = 10'b11100_11100,
        ErrorSt = 10'b00011_00011
    } otp_arb_state_e;

endpackage

// File: rtl/otp_ctrl_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i
// (wrapping around) wins.
module otp_ctrl_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW-1:0] cand;

    // Walk from the farthest candidate back to ptr_i so the nearest one wins.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = IdxW'((int'(ptr_i) + i) % NumReq);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/otp_ctrl_otp_arb.sv
// Round-robin arbiter sharing the OTP macro command port between requesters,
// with one outstanding transaction, escalation lock-down and a response watchdog.
module otp_ctrl_otp_arb
    import otp_ctrl_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  lc_tx_t                                    escalate_en_i,
    input  logic [NumReq-1:0]                         req_i,
    input  cmd_e [NumReq-1:0]                         cmd_i,
    input  logic [NumReq-1:0][OtpSizeWidth-1:0]       size_i,
    input  logic [NumReq-1:0][OtpIfWidth-1:0]         wdata_i,
    input  logic [NumReq-1:0][OtpAddrWidth-1:0]       addr_i,
    output logic [NumReq-1:0]                         gnt_o,
    output logic [NumReq-1:0]                         rvalid_o,
    output logic [ScrmblBlockWidth-1:0]               rdata_o,
    output err_e                                      err_o,
    output logic                                      otp_req_o,
    output cmd_e                                      otp_cmd_o,
    output logic [OtpSizeWidth-1:0]                   otp_size_o,
    output logic [OtpIfWidth-1:0]                     otp_wdata_o,
    output logic [OtpAddrWidth-1:0]                   otp_addr_o,
    input  logic                                      otp_gnt_i,
    input  logic                                      otp_rvalid_i,
    input  logic [ScrmblBlockWidth-1:0]               otp_rdata_i,
    input  err_e                                      otp_err_i,
    output logic                                      idle_o,
    output logic                                      fsm_err_o,
    output logic                                      timeout_err_o
);

    localparam int IdxW  = $clog2(NumReq);
    localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit WdEn  = TimeoutCycles > 0;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

    otp_arb_state_e                 state_q;
    logic [IdxW-1:0]                ptr_q, owner_q;
    cmd_e                           cmd_q;
    logic [OtpSizeWidth-1:0]        size_q;
    logic [OtpIfWidth-1:0]          wdata_q;
    logic [OtpAddrWidth-1:0]        addr_q;
    logic [CntW-1:0]                cnt_q;
    logic                           timeout_q;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;

    otp_ctrl_rr_pick #(
        .NumReq(NumReq)
    ) u_rr_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    logic esc, in_idle, in_req, in_wait, in_err, state_ok;
    logic gnt_fire, rsp_fire, unexp_rsp, wd_hit;

    assign esc       = lc_tx_test_true_loose(escalate_en_i);
    assign in_idle   = state_q == IdleSt;
    assign in_req    = state_q == ReqSt;
    assign in_wait   = state_q == WaitSt;
    assign in_err    = state_q == ErrorSt;
    assign state_ok  = in_idle | in_req | in_wait | in_err;
    assign unexp_rsp = (in_idle | in_req) & otp_rvalid_i;
    assign gnt_fire  = in_req & otp_gnt_i & ~otp_rvalid_i & ~esc;
    assign rsp_fire  = in_wait & otp_rvalid_i & ~esc;
    // A grant or response arriving on the last allowed cycle still counts.
    assign wd_hit    = WdEn & (in_req | in_wait) & (cnt_q >= CntLast) & ~gnt_fire & ~rsp_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IdleSt;
            ptr_q     <= '0;
            owner_q   <= '0;
            cmd_q     <= Read;
            size_q    <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((in_req || in_wait) && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                IdleSt: begin
                    if (pick_valid) begin
                        state_q <= ReqSt;
                        owner_q <= pick_idx;
                        cmd_q   <= cmd_i[pick_idx];
                        size_q  <= size_i[pick_idx];
                        wdata_q <= wdata_i[pick_idx];
                        addr_q  <= addr_i[pick_idx];
                        cnt_q   <= '0;
                    end
                end
                ReqSt: begin
                    if (gnt_fire) begin
                        state_q <= WaitSt;
                        ptr_q   <= (owner_q == IdxLast) ? '0 : owner_q + 1'b1;
                    end
                end
                WaitSt: begin
                    if (rsp_fire) begin
                        state_q <= IdleSt;
                    end
                end
                ErrorSt: ;
                default: state_q <= ErrorSt;
            endcase
            if (wd_hit) begin
                state_q   <= ErrorSt;
                timeout_q <= 1'b1;
            end
            if (esc || unexp_rsp) begin
                state_q <= ErrorSt;
            end
        end
    end

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            gnt_o[i]    = gnt_fire && (owner_q == IdxW'(i));
            rvalid_o[i] = rsp_fire && (owner_q == IdxW'(i));
        end
    end

    assign rdata_o       = rsp_fire ? otp_rdata_i : '0;
    assign err_o         = rsp_fire ? otp_err_i : NoError;
    assign otp_req_o     = in_req;
    assign otp_cmd_o     = in_req ? cmd_q : Read;
    assign otp_size_o    = in_req ? size_q : '0;
    assign otp_wdata_o   = in_req ? wdata_q : '0;
    assign otp_addr_o    = in_req ? addr_q : '0;
    assign idle_o        = in_idle & ~|req_i;
    assign fsm_err_o     = esc | ~state_ok | unexp_rsp;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_otp_ctrl_otp_arb.sv
// Directed bench for otp_ctrl_otp_arb: expected grant owners are queued when a
// request is driven and popped when the DUT grants and responds.
module tb_otp_ctrl_otp_arb;
    import otp_ctrl_pkg::*;

    localparam int NumReq = 4;
    localparam int Tc     = 8;

    logic                                  clk = 1'b0;
    logic                                  rst_n = 1'b0;
    lc_tx_t                                esc;
    logic [NumReq-1:0]                     req;
    cmd_e [NumReq-1:0]                     cmd;
    logic [NumReq-1:0][OtpSizeWidth-1:0]   size;
    logic [NumReq-1:0][OtpIfWidth-1:0]     wdata;
    logic [NumReq-1:0][OtpAddrWidth-1:0]   addr;
    logic [NumReq-1:0]                     gnt_o, rvalid_o;
    logic [ScrmblBlockWidth-1:0]           rdata_o;
    err_e                                  err_o;
    logic                                  otp_req_o;
    cmd_e                                  otp_cmd_o;
    logic [OtpSizeWidth-1:0]               otp_size_o;
    logic [OtpIfWidth-1:0]                 otp_wdata_o;
    logic [OtpAddrWidth-1:0]               otp_addr_o;
    logic                                  otp_gnt, otp_rvalid;
    logic [ScrmblBlockWidth-1:0]           otp_rdata;
    err_e                                  otp_err;
    logic                                  idle_o, fsm_err_o, timeout_err_o;

    int n_vec = 0;
    int n_err = 0;
    logic [NumReq-1:0] exp_q[$];
    logic [NumReq-1:0] rsp_q[$];

    otp_ctrl_otp_arb #(
        .NumReq       (NumReq),
        .TimeoutCycles(Tc)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .escalate_en_i(esc),
        .req_i        (req),
        .cmd_i        (cmd),
        .size_i       (size),
        .wdata_i      (wdata),
        .addr_i       (addr),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .otp_req_o    (otp_req_o),
        .otp_cmd_o    (otp_cmd_o),
        .otp_size_o   (otp_size_o),
        .otp_wdata_o  (otp_wdata_o),
        .otp_addr_o   (otp_addr_o),
        .otp_gnt_i    (otp_gnt),
        .otp_rvalid_i (otp_rvalid),
        .otp_rdata_i  (otp_rdata),
        .otp_err_i    (otp_err),
        .idle_o       (idle_o),
        .fsm_err_o    (fsm_err_o),
        .timeout_err_o(timeout_err_o)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before limit");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_gnt(input string tag);
        logic [NumReq-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, 64'(gnt_o), 64'(e));
        rsp_q.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        logic [NumReq-1:0] e;
        e = (rsp_q.size() > 0) ? rsp_q.pop_front() : 'x;
        check(tag, 64'(rvalid_o), 64'(e));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle();
        check("rst_otp_req", 64'(otp_req_o), 0);
        check("rst_timeout", 64'(timeout_err_o), 0);
        tick();
        rst_n = 1'b1;
        settle();
        exp_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        esc        = LcTxOff;
        req        = '0;
        for (int i = 0; i < NumReq; i++) cmd[i] = Read;
        size       = '0;
        wdata      = '0;
        addr       = '0;
        otp_gnt    = 1'b0;
        otp_rvalid = 1'b0;
        otp_rdata  = '0;
        otp_err    = NoError;
        tick();
        tick();

        // Reset values.
        check("rst_gnt", 64'(gnt_o), 0);
        check("rst_rvalid", 64'(rvalid_o), 0);
        check("rst_rdata", 64'(rdata_o), 0);
        check("rst_err", 64'(err_o), 64'(NoError));
        check("rst_fsm_err", 64'(fsm_err_o), 0);
        check("rst_idle", 64'(idle_o), 1);
        check("rst_cmd", 64'(otp_cmd_o), 64'(Read));
        rst_n = 1'b1;
        tick();

        // Single request from requester 2.
        req      = 4'b0100;
        cmd[2]   = Write;
        addr[2]  = 11'h12;
        wdata[2] = 64'h1234;
        size[2]  = 2'd1;
        exp_q.push_back(4'b0100);
        settle();
        check("t1_idle_req", 64'(otp_req_o), 0);
        check("t1_idle_o", 64'(idle_o), 0);
        tick();
        check("t1_req", 64'(otp_req_o), 1);
        check("t1_addr", 64'(otp_addr_o), 64'h12);
        check("t1_cmd", 64'(otp_cmd_o), 64'(Write));
        check("t1_size", 64'(otp_size_o), 1);
        check("t1_nognt", 64'(gnt_o), 0);
        tick();
        check("t1_nognt2", 64'(gnt_o), 0);
        tick();
        otp_gnt = 1'b1;
        settle();
        check_gnt("t1_gnt");
        tick();
        otp_gnt = 1'b0;
        req     = '0;
        settle();
        check("t1_wait_req", 64'(otp_req_o), 0);
        check("t1_wait_addr", 64'(otp_addr_o), 0);
        check("t1_wait_rv", 64'(rvalid_o), 0);
        tick();
        tick();
        otp_rvalid = 1'b1;
        otp_rdata  = 64'hdead_beef_0123_4567;
        otp_err    = MacroEccCorrError;
        settle();
        check_rsp("t1_rvalid");
        check("t1_rdata", 64'(rdata_o), 64'hdead_beef_0123_4567);
        check("t1_err", 64'(err_o), 64'(MacroEccCorrError));
        tick();
        otp_rvalid = 1'b0;
        otp_err    = NoError;
        settle();
        check("t1_idle_back", 64'(idle_o), 1);
        check("t1_rdata_clr", 64'(rdata_o), 0);

        // All requesters held from a fresh pointer: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NumReq; i++) begin
            addr[i] = 11'(i);
            cmd[i]  = Read;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(4'b0001 << (k % NumReq));
        settle();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_bubble%0d", k), 64'(otp_req_o), 0);
            tick();
            otp_gnt = 1'b1;
            settle();
            check($sformatf("rr_addr%0d", k), 64'(otp_addr_o), 64'(k % NumReq));
            check_gnt($sformatf("rr_gnt%0d", k));
            tick();
            otp_gnt    = 1'b0;
            otp_rvalid = 1'b1;
            settle();
            check_rsp($sformatf("rr_rvalid%0d", k));
            tick();
            otp_rvalid = 1'b0;
            settle();
        end
        req = '0;
        settle();
        check("rr_idle", 64'(idle_o), 1);

        // Payload is latched at selection time.
        req      = 4'b0010;
        wdata[1] = 64'hAAAA;
        exp_q.push_back(4'b0010);
        settle();
        tick();
        check("latch_w0", 64'(otp_wdata_o), 64'hAAAA);
        wdata[1] = 64'h5555;
        settle();
        check("latch_w1", 64'(otp_wdata_o), 64'hAAAA);
        tick();
        check("latch_w2", 64'(otp_wdata_o), 64'hAAAA);
        tick();
        otp_gnt = 1'b1;
        settle();
        check("latch_w3", 64'(otp_wdata_o), 64'hAAAA);
        check_gnt("latch_gnt");
        tick();
        otp_gnt    = 1'b0;
        req        = '0;
        otp_rvalid = 1'b1;
        settle();
        check("latch_wdata_clr", 64'(otp_wdata_o), 0);
        check_rsp("latch_rvalid");
        tick();
        otp_rvalid = 1'b0;
        settle();

        // Response on the last cycle the watchdog allows is still accepted.
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        settle();
        tick();
        otp_gnt = 1'b1;
        settle();
        check_gnt("edge_gnt");
        tick();
        otp_gnt = 1'b0;
        req     = '0;
        repeat (6) tick();
        otp_rvalid = 1'b1;
        settle();
        check_rsp("edge_rvalid");
        check("edge_timeout", 64'(timeout_err_o), 0);
        tick();
        otp_rvalid = 1'b0;
        settle();
        check("edge_idle", 64'(idle_o), 1);
        check("edge_fsm_err", 64'(fsm_err_o), 0);

        // Escalation in WaitSt beats a simultaneous response.
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        settle();
        tick();
        otp_gnt = 1'b1;
        settle();
        check_gnt("esc_gnt");
        tick();
        otp_gnt    = 1'b0;
        req        = '0;
        esc        = LcTxOn;
        otp_rvalid = 1'b1;
        settle();
        check("esc_rvalid", 64'(rvalid_o), 0);
        check("esc_fsm_err", 64'(fsm_err_o), 1);
        void'(rsp_q.pop_front());
        tick();
        esc        = LcTxOff;
        otp_rvalid = 1'b0;
        req        = 4'b0001;
        settle();
        check("esc_fsm_err_off", 64'(fsm_err_o), 0);
        check("esc_not_idle", 64'(idle_o), 0);
        tick();
        check("esc_locked_req", 64'(otp_req_o), 0);
        otp_gnt = 1'b1;
        settle();
        check("esc_locked_gnt", 64'(gnt_o), 0);
        otp_gnt = 1'b0;

        // Watchdog: no grant ever arrives.
        do_reset();
        req = 4'b0001;
        settle();
        tick();
        for (int i = 0; i < Tc; i++) begin
            check($sformatf("wd_req%0d", i), 64'(otp_req_o), 1);
            tick();
        end
        check("wd_err_req", 64'(otp_req_o), 0);
        check("wd_timeout", 64'(timeout_err_o), 1);
        repeat (3) tick();
        check("wd_sticky", 64'(timeout_err_o), 1);
        req = '0;

        // Unexpected response in IdleSt, then reset recovers with ptr=0.
        do_reset();
        check("ux_idle", 64'(idle_o), 1);
        otp_rvalid = 1'b1;
        settle();
        check("ux_fsm_err", 64'(fsm_err_o), 1);
        check("ux_rvalid", 64'(rvalid_o), 0);
        tick();
        otp_rvalid = 1'b0;
        settle();
        check("ux_fsm_err_off", 64'(fsm_err_o), 0);
        check("ux_not_idle", 64'(idle_o), 0);
        req = 4'b0100;
        tick();
        check("ux_locked", 64'(otp_req_o), 0);
        req = 4'b1111;
        do_reset();
        exp_q.push_back(4'b0001);
        tick();
        otp_gnt = 1'b1;
        settle();
        check("ux_ptr0_addr", 64'(otp_addr_o), 0);
        check_gnt("ux_ptr0_gnt");
        tick();
        otp_gnt    = 1'b0;
        req        = '0;
        otp_rvalid = 1'b1;
        settle();
        check_rsp("ux_ptr0_rvalid");
        tick();
        otp_rvalid = 1'b0;
        esc        = 4'b0011;
        settle();
        check("esc_loose", 64'(fsm_err_o), 1);
        tick();
        esc = LcTxOff;
        req = 4'b0001;
        tick();
        check("esc_loose_locked", 64'(otp_req_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
